// File: rtl/acc_bank.sv
// Bank of N_ACC accumulators with per-accumulator ALU and C/Z/N/V flags,
// optional signed saturation, and a shared LIFO save/restore stack.
package acc_bank_pkg;
  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_XOR  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } op_e;
endpackage

module acc_slice
  import acc_bank_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SAT   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] pop_d,
  output logic [WIDTH-1:0] acc,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v
);
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] res;
  logic             rc, rv;

  assign sum = {1'b0, acc} + {1'b0, din};
  assign dif = {1'b0, acc} - {1'b0, din};

  always_comb begin
    res = acc;
    rc  = 1'b0;
    rv  = 1'b0;
    case (op)
      OP_LOAD: res = din;
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        rc  = sum[WIDTH];
        rv  = (acc[WIDTH-1] == din[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
      end
      OP_SUB: begin
        res = dif[WIDTH-1:0];
        rc  = dif[WIDTH];
        rv  = (acc[WIDTH-1] != din[WIDTH-1]) && (dif[WIDTH-1] != acc[WIDTH-1]);
      end
      OP_AND:  res = acc & din;
      OP_XOR:  res = acc ^ din;
      OP_POP:  res = pop_d;
      default: res = acc;
    endcase
    // On overflow the true result always carries the sign of the old acc
    if (SAT != 0 && rv)
      res = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
      c   <= 1'b0;
      z   <= 1'b0;
      n   <= 1'b0;
      v   <= 1'b0;
    end else if (we) begin
      acc <= res;
      c   <= rc;
      v   <= rv;
      z   <= (res == '0);
      n   <= res[WIDTH-1];
    end
  end
endmodule

module acc_bank
  import acc_bank_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int N_ACC       = 2,
  parameter int STACK_DEPTH = 4,
  parameter int SAT         = 0,
  localparam int SW = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [SW-1:0]    SEL,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic             C,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             STK_FULL,
  output logic             STK_EMPTY,
  output logic             ERR
);
  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [N_ACC-1:0][WIDTH-1:0] accs;
  logic [N_ACC-1:0]            cs, zs, ns, vs, we;
  logic [WIDTH-1:0]            stk [STACK_DEPTH];
  logic [PW-1:0]               ptr;
  logic [WIDTH-1:0]            top_d;
  logic                        sel_ok, alu_op, push_ok, pop_ok, err_nxt;

  // Unmatched SEL (non-power-of-2 bank) falls through to zeros
  always_comb begin
    OUT    = '0;
    C      = 1'b0;
    Z      = 1'b0;
    N      = 1'b0;
    V      = 1'b0;
    sel_ok = 1'b0;
    for (int i = 0; i < N_ACC; i++) begin
      if (SEL == SW'(i)) begin
        OUT    = accs[i];
        C      = cs[i];
        Z      = zs[i];
        N      = ns[i];
        V      = vs[i];
        sel_ok = 1'b1;
      end
    end
  end

  assign STK_FULL  = (ptr == PW'(STACK_DEPTH));
  assign STK_EMPTY = (ptr == '0);
  assign alu_op    = (OP == OP_LOAD) || (OP == OP_ADD) || (OP == OP_SUB) ||
                     (OP == OP_AND)  || (OP == OP_XOR);
  assign push_ok   = CE && sel_ok && (OP == OP_PUSH) && !STK_FULL;
  assign pop_ok    = CE && sel_ok && (OP == OP_POP)  && !STK_EMPTY;
  assign err_nxt   = CE && (!sel_ok || ((OP == OP_PUSH) && STK_FULL) ||
                                       ((OP == OP_POP)  && STK_EMPTY));
  assign top_d     = stk[IW'(ptr - PW'(1))];

  generate
    for (genvar g = 0; g < N_ACC; g++) begin : g_acc
      assign we[g] = CE && (SEL == SW'(g)) && (alu_op || pop_ok);
      acc_slice #(.WIDTH(WIDTH), .SAT(SAT)) u_slice (
        .CLK   (CLK),
        .RST   (RST),
        .we    (we[g]),
        .op    (OP),
        .din   (IN),
        .pop_d (top_d),
        .acc   (accs[g]),
        .c     (cs[g]),
        .z     (zs[g]),
        .n     (ns[g]),
        .v     (vs[g])
      );
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= '0;
      ERR <= 1'b0;
    end else begin
      ERR <= err_nxt;
      if (push_ok)     ptr <= ptr + PW'(1);
      else if (pop_ok) ptr <= ptr - PW'(1);
    end
  end

  // Stack storage needs no reset; the pointer alone defines validity
  always_ff @(posedge CLK) begin
    if (push_ok && !RST) stk[IW'(ptr)] <= OUT;
  end
endmodule
